// File: rtl/fetch_unit_v2.sv
// Instruction store and fetch stage. Holds program memory (loaded through the
// write port), owns the fetch PC, applies branch/jump redirects, runs a short
// interrupt entry sequence and inserts bubbles on load-use / pop-use hazards.
module fetch_unit_v2 #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned RESET_PC   = 32,
  parameter int unsigned IRQ_VEC    = 0,
  parameter int unsigned LOAD_OPC   = 10,
  parameter int unsigned POP_OPC    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall_in,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              direct_jump,
  input  logic [ADDR_W-1:0] direct_addr,
  input  logic              irq,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ret_pc,
  output logic              irq_save,
  output logic              hazard
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] IrqVec  = ADDR_W'(IRQ_VEC);
  localparam logic [4:0]        LoadOpc = 5'(LOAD_OPC);
  localparam logic [4:0]        PopOpc  = 5'(POP_OPC);

  typedef enum logic [1:0] {
    StRun,
    StIrqSave,
    StIrqFetch
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              irq_q;

  logic [DATA_W-1:0] instr_d;
  logic              instr_valid_d;
  logic [ADDR_W-1:0] pc_out_d;
  logic [ADDR_W-1:0] ret_pc_d;
  logic              irq_save_d;
  logic              hazard_d;

  logic              irq_edge;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] vec_word;
  logic              is_hazard;
  logic              load_hit;
  logic              pop_hit;

  // Addresses at or above DEPTH are outside the store.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  // Program load port; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr)) begin
      mem[wr_addr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Fetch target selection, candidate word lookup and hazard detection.
  always_comb begin
    irq_edge = irq & ~irq_q & ~wr_en;
    redirect = jump_taken | direct_jump;
    if (jump_taken) begin
      target = jump_addr;
    end else if (direct_jump) begin
      target = direct_addr;
    end else begin
      target = fetch_pc_q;
    end
    cand     = in_range(target) ? mem[target[DEPTH_LOG2-1:0]] : '0;
    vec_word = in_range(IrqVec) ? mem[IrqVec[DEPTH_LOG2-1:0]] : '0;
    // A bubble in the decode slot never produces a hazard.
    load_hit = (instr[15:11] == LoadOpc) &&
               ((instr[7:5] == cand[7:5]) || (instr[7:5] == cand[10:8]));
    pop_hit  = (instr[15:11] == PopOpc) &&
               ((instr[10:8] == cand[7:5]) || (instr[10:8] == cand[10:8]));
    is_hazard = instr_valid & (load_hit | pop_hit);
  end

  // Next-state and output logic; everything holds unless a branch below says otherwise.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    pc_out_d      = pc_out;
    ret_pc_d      = ret_pc;
    irq_save_d    = irq_save;
    hazard_d      = hazard;

    unique case (state_q)
      StRun: begin
        if (wr_en) begin
          // Program-load mode freezes the whole fetch stage.
        end else if (irq_edge) begin
          // Save slot: target already folds in any redirect present on this edge.
          state_d       = StIrqSave;
          instr_d       = '0;
          instr_valid_d = 1'b0;
          irq_save_d    = 1'b1;
          hazard_d      = 1'b0;
          ret_pc_d      = target;
        end else if (redirect || !stall_in) begin
          if (is_hazard) begin
            // Insert a bubble and refetch the same word next cycle.
            instr_d       = '0;
            instr_valid_d = 1'b0;
            hazard_d      = 1'b1;
            fetch_pc_d    = target;
          end else begin
            instr_d       = cand;
            instr_valid_d = 1'b1;
            pc_out_d      = target;
            fetch_pc_d    = target + ADDR_W'(1);
            hazard_d      = 1'b0;
          end
        end
      end
      StIrqSave: begin
        if (!wr_en) begin
          state_d    = StIrqFetch;
          irq_save_d = 1'b0;
        end
      end
      StIrqFetch: begin
        if (!wr_en) begin
          // Vector fetch skips the hazard check: the slot before it is a bubble.
          state_d       = StRun;
          instr_d       = vec_word;
          instr_valid_d = 1'b1;
          pc_out_d      = IrqVec;
          fetch_pc_d    = IrqVec + ADDR_W'(1);
          hazard_d      = 1'b0;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Fetch state and registered decode-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      fetch_pc_q  <= ResetPc;
      irq_q       <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      ret_pc      <= '0;
      irq_save    <= 1'b0;
      hazard      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      irq_q       <= irq;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      pc_out      <= pc_out_d;
      ret_pc      <= ret_pc_d;
      irq_save    <= irq_save_d;
      hazard      <= hazard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit_v2.sv
// Directed bench for fetch_unit_v2: expected decode-slot contents are queued
// when stimulus is applied and compared after the following clock edge.
module tb_fetch_unit_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        stall_in;
  logic        jump_taken;
  logic [15:0] jump_addr;
  logic        direct_jump;
  logic [15:0] direct_addr;
  logic        irq;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] ret_pc;
  logic        irq_save;
  logic        hazard;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] instr;
    logic        valid;
    logic        chk_pc;
    logic [15:0] pc;
    logic        hz;
    logic        save;
  } exp_t;

  exp_t sb[$];

  fetch_unit_v2 dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .stall_in    (stall_in),
    .jump_taken  (jump_taken),
    .jump_addr   (jump_addr),
    .direct_jump (direct_jump),
    .direct_addr (direct_addr),
    .irq         (irq),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .ret_pc      (ret_pc),
    .irq_save    (irq_save),
    .hazard      (hazard)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] s,
                                     input logic [2:0] d, input logic [4:0] lo);
    return {op, s, d, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] i, input logic v,
                            input logic cp, input logic [15:0] pc, input logic hz,
                            input logic sv);
    exp_t e;
    e.tag = tag; e.instr = i; e.valid = v; e.chk_pc = cp; e.pc = pc; e.hz = hz; e.save = sv;
    sb.push_back(e);
  endtask

  // Advance one clock, then drain the scoreboard against the registered outputs.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".instr"}, 32'(instr), 32'(e.instr));
      check({e.tag, ".valid"}, 32'(instr_valid), 32'(e.valid));
      if (e.chk_pc) check({e.tag, ".pc_out"}, 32'(pc_out), 32'(e.pc));
      check({e.tag, ".hazard"}, 32'(hazard), 32'(e.hz));
      check({e.tag, ".irq_save"}, 32'(irq_save), 32'(e.save));
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".instr"}, 32'(instr), 32'h0);
    check({tag, ".valid"}, 32'(instr_valid), 32'h0);
    check({tag, ".pc_out"}, 32'(pc_out), 32'h0);
    check({tag, ".ret_pc"}, 32'(ret_pc), 32'h0);
    check({tag, ".irq_save"}, 32'(irq_save), 32'h0);
    check({tag, ".hazard"}, 32'(hazard), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a_w, b_w, c_w, d_w, v0_w, v1_w, j_w, k_w, w6_w, ld_w, u_w, pp_w, u2_w;
    a_w  = mk(5'd1, 3'd1, 3'd2, 5'd1);
    b_w  = mk(5'd1, 3'd2, 3'd4, 5'd2);
    c_w  = mk(5'd2, 3'd3, 3'd5, 5'd3);
    d_w  = mk(5'd3, 3'd4, 3'd6, 5'd4);
    v0_w = mk(5'd4, 3'd0, 3'd1, 5'd5);
    v1_w = mk(5'd4, 3'd1, 3'd2, 5'd6);
    j_w  = mk(5'd5, 3'd2, 3'd3, 5'd7);
    k_w  = mk(5'd5, 3'd3, 3'd4, 5'd8);
    w6_w = mk(5'd6, 3'd5, 3'd6, 5'd9);
    ld_w = mk(5'd10, 3'd1, 3'd3, 5'd0);  // load, dst=3
    u_w  = mk(5'd1, 3'd3, 3'd7, 5'd1);   // src=3 -> load-use
    pp_w = mk(5'd9, 3'd5, 3'd0, 5'd2);   // pop, [10:8]=5
    u2_w = mk(5'd1, 3'd2, 3'd5, 5'd3);   // dst=5 -> pop-use

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; stall_in = 1'b0;
    jump_taken = 1'b0; jump_addr = '0; direct_jump = 1'b0; direct_addr = '0; irq = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");

    // Program load; fetch must stay frozen throughout.
    rst = 1'b1;
    wr(16'd32, a_w); wr(16'd33, b_w); wr(16'd34, c_w); wr(16'd35, d_w);
    wr(16'd0, v0_w); wr(16'd1, v1_w); wr(16'd40, j_w); wr(16'd41, k_w);
    wr(16'd6, w6_w); wr(16'd50, ld_w); wr(16'd51, u_w); wr(16'd52, pp_w);
    wr(16'd53, u2_w);
    expect_out("wr_oob_frozen", 16'h0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
    wr(16'd70, 16'hBEEF);

    // Sequential fetch from RESET_PC.
    expect_out("seq32", a_w, 1'b1, 1'b1, 16'd32, 1'b0, 1'b0); step();
    expect_out("seq33", b_w, 1'b1, 1'b1, 16'd33, 1'b0, 1'b0); step();
    expect_out("seq34", c_w, 1'b1, 1'b1, 16'd34, 1'b0, 1'b0); step();
    expect_out("seq35", d_w, 1'b1, 1'b1, 16'd35, 1'b0, 1'b0); step();

    // Interrupt while pc_out=35: save slot, extra bubble, then vector.
    irq = 1'b1;
    expect_out("irq_save", 16'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1); step();
    check("irq_ret_pc", 32'(ret_pc), 32'd36);
    expect_out("irq_fetch", 16'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0); step();
    expect_out("irq_vec", v0_w, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0); step();
    expect_out("irq_held", v1_w, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0); step();
    irq = 1'b0;

    // Redirect overrides stall; stall alone holds; then continue at 41.
    stall_in = 1'b1; jump_taken = 1'b1; jump_addr = 16'd40;
    expect_out("jmp_stall", j_w, 1'b1, 1'b1, 16'd40, 1'b0, 1'b0); step();
    jump_taken = 1'b0;
    expect_out("stall_hold", j_w, 1'b1, 1'b1, 16'd40, 1'b0, 1'b0); step();
    stall_in = 1'b0;
    expect_out("after_jmp", k_w, 1'b1, 1'b1, 16'd41, 1'b0, 1'b0); step();

    // jump_taken beats direct_jump; mem[6] must not have been hit by the addr-70 write.
    jump_taken = 1'b1; jump_addr = 16'd6; direct_jump = 1'b1; direct_addr = 16'd32;
    expect_out("jmp_prio", w6_w, 1'b1, 1'b1, 16'd6, 1'b0, 1'b0); step();
    jump_taken = 1'b0; direct_addr = 16'd50;
    expect_out("djmp", ld_w, 1'b1, 1'b1, 16'd50, 1'b0, 1'b0); step();
    direct_jump = 1'b0;

    // Load-use and pop-use bubbles.
    expect_out("ld_bubble", 16'h0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0); step();
    expect_out("ld_refetch", u_w, 1'b1, 1'b1, 16'd51, 1'b0, 1'b0); step();
    expect_out("pop", pp_w, 1'b1, 1'b1, 16'd52, 1'b0, 1'b0); step();
    expect_out("pop_bubble", 16'h0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0); step();
    expect_out("pop_refetch", u2_w, 1'b1, 1'b1, 16'd53, 1'b0, 1'b0); step();

    // Out-of-range fetch yields a zero word.
    direct_jump = 1'b1; direct_addr = 16'd100;
    expect_out("oob_fetch", 16'h0, 1'b1, 1'b1, 16'd100, 1'b0, 1'b0); step();
    direct_jump = 1'b0;

    // Interrupt coincident with a redirect saves the redirect target.
    irq = 1'b1; jump_taken = 1'b1; jump_addr = 16'd40;
    expect_out("irq_jmp_save", 16'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1); step();
    check("irq_jmp_ret_pc", 32'(ret_pc), 32'd40);
    jump_taken = 1'b0; irq = 1'b0;
    expect_out("irq_jmp_fetch", 16'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0); step();
    expect_out("irq_jmp_vec", v0_w, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0); step();

    // Re-armed interrupt, then reset in the save slot.
    irq = 1'b1;
    expect_out("irq2_save", 16'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1); step();
    rst = 1'b0;
    #2;
    check_reset("mid_reset");
    rst = 1'b1; irq = 1'b0;
    expect_out("post_reset", a_w, 1'b1, 1'b1, 16'd32, 1'b0, 1'b0); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
